mem_latency_responder: RTL and testbench
========================================

MEM_LATENCY_RESPONDER -- requirements
Module: mem_latency_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; 0 resets the block.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port req_write, input, 1, 1 means write and 0 means read.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, write data.
REQ-010 SHALL have port resp_valid, output, 1, single-cycle completion pulse for reads and writes.
REQ-011 SHALL have port resp_rdata, output, 32, read data, valid only while resp_valid=1 for a read.
REQ-012 SHALL have port resp_err, output, 1, misaligned-access flag, valid with resp_valid.

Function
REQ-013 SHALL accept a request at rising edge k exactly when req_valid=1 and req_ready=1; it SHALL capture write, addr and wdata at that edge.
REQ-014 SHALL hold at most one request outstanding.
REQ-015 SHALL use FSM states IDLE, WAIT and RESP.
REQ-016 SHALL make these transitions: IDLE->WAIT on accept when LATENCY>1; IDLE->RESP on accept when LATENCY=1; WAIT->RESP when the down-counter reaches 1; RESP->WAIT or RESP on accept; RESP->IDLE otherwise.
REQ-017 SHALL load the down-counter with LATENCY-1 on accept and decrement it once per cycle in WAIT.
REQ-018 SHALL, for a request accepted at edge k, have resp_valid=1 sampled at edge k+LATENCY and for that one cycle only.
REQ-019 SHALL drive req_ready=1 in IDLE and in RESP (back-to-back requests), and 0 in WAIT.
REQ-020 SHALL index storage with word index addr[31:2] modulo DEPTH; out-of-range addresses wrap and SHALL NOT raise an error.
REQ-021 SHALL drive resp_rdata on a read with the storage word as of the acceptance edge.
REQ-022 SHALL commit a write at edge k+LATENCY, the response edge.
REQ-023 SHALL drive resp_rdata=0 on a write response and whenever resp_valid=0.
REQ-024 SHALL, for a read accepted in RESP while that cycle's write commits to the same word, return the newly written data.
REQ-025 SHALL ignore req_write, req_addr and req_wdata when no accept occurs.

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, counter=0, req_ready=1 immediately after release, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-027 SHALL discard any pending request on reset mid-operation; a pending write SHALL NOT commit and no response SHALL follow.
REQ-028 SHALL NOT clear storage contents on reset.

Configuration
REQ-029 SHALL, with MEM_MISALIGN_CHECK_EN defined, raise resp_err=1 with the response when req_addr[1:0]!=0; a misaligned write SHALL NOT commit and a misaligned read SHALL return resp_rdata=0.
REQ-030 SHALL, without MEM_MISALIGN_CHECK_EN, tie resp_err to 0 and ignore addr[1:0].

Structure
REQ-031 SHALL place the FSM state encoding, default LATENCY and DEPTH, and the word-offset width in shared package mem_pkg.
REQ-032 SHALL put storage in one sub-module mem_array: single write port and asynchronous read, parameterized by DEPTH.

Verification
REQ-033 SHALL cover: LATENCY=4, write 0xDEADBEEF to 0x10 at edge 5 -> resp_valid at edge 9; read 0x10 at edge 10 -> resp_valid at edge 14 with rdata=0xDEADBEEF.
REQ-034 SHALL cover: LATENCY=4, req_valid held high across 3 reads -> req_ready=0 in WAIT and resp_valid at edges k+4, k+8 and k+12 with no bubbles.
REQ-035 SHALL cover: LATENCY=1, write 0x5 to 0x20 then same-cycle read 0x20 in RESP -> read returns 0x5 one cycle later.
REQ-036 SHALL cover: DEPTH=1024, write 0xA5 to 0x1000 -> read 0x0 returns 0xA5 (wrap).
REQ-037 SHALL cover: reset asserted 2 cycles after accepting write 0x77 to 0x8 -> no resp_valid, req_ready=1 after release, read 0x8 returns the prior value.
REQ-038 SHALL cover: with MEM_MISALIGN_CHECK_EN defined, write to 0x13 -> resp_err=1 and memory unchanged; without it -> resp_err=0 and word 0x10 written.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory latency responder:
//   - state_t          : responder FSM encoding (IDLE, WAIT, RESP)
//   - DEFAULT_DEPTH    : default storage depth in 32-bit words
//   - DEFAULT_LATENCY  : default request-to-response latency in cycles
//   - WORD_OFF_W       : width of the byte offset inside a 32-bit word
//   - CNT_W            : width of the latency down-counter (LATENCY <= 15)
//   - is_misaligned()  : true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 4;
  localparam int WORD_OFF_W      = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[WORD_OFF_W-1:0] != {WORD_OFF_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Word storage with one synchronous write port and one asynchronous read port.
// Contents are never reset.
// Parameters:
//   DEPTH  number of 32-bit words (power of two)
// Ports:
//   clk    clock
//   we     write enable, write lands on the rising edge
//   waddr  write word index
//   wdata  write data
//   raddr  read word index
//   rdata  read data (combinational)
// -----------------------------------------------------------------------------
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_latency_responder.sv
// -----------------------------------------------------------------------------
// mem_latency_responder
// Single-outstanding memory responder with a fixed request-to-response latency.
// A request accepted at edge k produces a one-cycle resp_valid sampled at edge
// k+LATENCY; writes commit on that same response edge.
// Optional build macro:
//   MEM_MISALIGN_CHECK_EN  flag non-word-aligned accesses with resp_err; such
//                          writes are dropped and such reads return zero.
// Parameters:
//   DEPTH    storage depth in 32-bit words (power of two)
//   LATENCY  cycles from acceptance to response, 1..15
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready handshake, req_write, req_addr (byte), req_wdata
//   resp_valid (one-cycle pulse), resp_rdata, resp_err
// -----------------------------------------------------------------------------
module mem_latency_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int               AW           = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam state_t           ACCEPT_STATE = (LATENCY == 1) ? RESP : WAIT;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Captured request
  logic          p_write, p_mis;
  logic [AW-1:0] p_idx;
  logic [31:0]   p_wdata, p_rdata;
  logic          n_write, n_mis;
  logic [AW-1:0] n_idx;
  logic [31:0]   n_wdata, n_rdata;

  logic          accept, in_mis, commit;
  logic [AW-1:0] in_idx;
  logic [31:0]   mem_rdata, rd_word;
  logic          resp_valid_n, resp_err_n, req_ready_n;
  logic [31:0]   resp_rdata_n;
  logic          unused_addr;

  assign accept = req_valid & req_ready;
  // Word index wraps modulo DEPTH: upper address bits are simply dropped.
  assign in_idx = req_addr[WORD_OFF_W +: AW];
  assign unused_addr = ^{req_addr[31:WORD_OFF_W+AW], req_addr[WORD_OFF_W-1:0]};

`ifdef MEM_MISALIGN_CHECK_EN
  assign in_mis = is_misaligned(req_addr);
`else
  assign in_mis = 1'b0;
`endif

  // The pending write lands on the response edge, i.e. the last RESP cycle.
  assign commit = (state == RESP) & p_write & ~p_mis;

  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (commit),
    .waddr (p_idx),
    .wdata (p_wdata),
    .raddr (in_idx),
    .rdata (mem_rdata)
  );

  // Read captured at acceptance sees a write committing on the same edge.
  always_comb begin
    if (commit && (p_idx == in_idx)) begin
      rd_word = p_wdata;
    end else begin
      rd_word = mem_rdata;
    end
  end

  // FSM next state and latency down-counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_n = ACCEPT_STATE;
          cnt_n   = CNT_LOAD;
        end else begin
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  // Request capture: load on accept, otherwise hold.
  always_comb begin
    n_write = p_write;
    n_mis   = p_mis;
    n_idx   = p_idx;
    n_wdata = p_wdata;
    n_rdata = p_rdata;
    if (accept) begin
      n_write = req_write;
      n_mis   = in_mis;
      n_idx   = in_idx;
      n_wdata = req_wdata;
      n_rdata = rd_word;
    end else begin
      n_write = p_write;
      n_mis   = p_mis;
      n_idx   = p_idx;
      n_wdata = p_wdata;
      n_rdata = p_rdata;
    end
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    resp_valid_n = (state_n == RESP);
    req_ready_n  = (state_n != WAIT);
    resp_err_n   = resp_valid_n & n_mis;
    if (resp_valid_n && !n_write && !n_mis) begin
      resp_rdata_n = n_rdata;
    end else begin
      resp_rdata_n = 32'd0;
    end
  end

  // State, pending request and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= CNT_ZERO;
      p_write    <= 1'b0;
      p_mis      <= 1'b0;
      p_idx      <= {AW{1'b0}};
      p_wdata    <= 32'd0;
      p_rdata    <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      p_write    <= n_write;
      p_mis      <= n_mis;
      p_idx      <= n_idx;
      p_wdata    <= n_wdata;
      p_rdata    <= n_rdata;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
    end
  end

endmodule

// File: tb/tb_mem_latency_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_latency_responder
// Two responders (LATENCY=4 and LATENCY=1, DEPTH=1024) driven by directed
// sequences and random traffic. A transaction-level model per instance
// (outstanding request with a due edge, word array) predicts the outputs for
// every cycle; directed sequences pin latencies and data with literal values.
// Honours MEM_MISALIGN_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_latency_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  mem_latency_responder #(.DEPTH(1024), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  mem_latency_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle comparison, one per instance.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int LAT = (g == 0) ? 4 : 1;
    logic [31:0] m [1024];
    bit          k [1024];
    bit          busy = 1'b0;
    int          due  = 0;
    int          lcyc = 0;
    bit          acc;
    bit          o_write, o_mis, o_known;
    int          o_idx;
    logic [31:0] o_wdata, o_rdata;
    bit          exp_valid = 1'b0, exp_ready = 1'b1, exp_err = 1'b0, exp_known = 1'b1;
    logic [31:0] exp_rdata = 32'd0;

    initial forever begin
      @(posedge clk or negedge reset[g]);
      if (reset[g] !== 1'b1) begin
        busy      = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        exp_err   = 1'b0;
        exp_known = 1'b1;
        exp_rdata = 32'd0;
      end else begin
        lcyc++;
        acc = (req_valid[g] === 1'b1) && exp_ready;
        if (busy && due == lcyc) begin
          if (o_write && !o_mis) begin
            m[o_idx] = o_wdata;
            k[o_idx] = 1'b1;
          end
          busy = 1'b0;
        end
        if (acc) begin
          busy    = 1'b1;
          due     = lcyc + LAT;
          o_write = req_write[g];
          o_idx   = int'((req_addr[g] >> 2) % 32'd1024);
          o_wdata = req_wdata[g];
`ifdef MEM_MISALIGN_CHECK_EN
          o_mis   = (req_addr[g] % 32'd4) != 32'd0;
`else
          o_mis   = 1'b0;
`endif
          o_rdata = m[o_idx];
          o_known = k[o_idx];
        end
        exp_valid = busy && (due == lcyc + 1);
        exp_ready = !busy || (due == lcyc + 1);
        exp_err   = exp_valid && o_mis;
        exp_known = !exp_valid || o_write || o_mis || o_known;
        exp_rdata = (exp_valid && !o_write && !o_mis) ? o_rdata : 32'd0;
      end
    end

    initial forever begin
      @(negedge clk);
      check($sformatf("resp_valid[%0d]", g), {31'd0, resp_valid[g]}, {31'd0, exp_valid});
      check($sformatf("req_ready[%0d]", g),  {31'd0, req_ready[g]},  {31'd0, exp_ready});
      check($sformatf("resp_err[%0d]", g),   {31'd0, resp_err[g]},   {31'd0, exp_err});
      if (exp_known) begin
        check($sformatf("resp_rdata[%0d]", g), resp_rdata[g], exp_rdata);
      end
    end
  end

  // One request on instance i; called and returns at posedge+2.
  task automatic do_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit err, output int lat);
    int acc_edge;
    bit r;
    rd  = 32'd0;
    err = 1'b0;
    lat = -1;
    acc_edge = -1;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    for (int t = 0; t < 40 && acc_edge < 0; t++) begin
      @(negedge clk);
      r = req_ready[i];
      @(posedge clk);
      #1;
      if (r) acc_edge = cyc;
      #1;
    end
    req_valid[i] = 1'b0;
    req_write[i] = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    if (acc_edge < 0) begin
      timeout_fail("accept");
    end else begin
      for (int t = 0; t < 40 && lat < 0; t++) begin
        @(negedge clk);
        if (resp_valid[i]) begin
          lat = cyc + 1 - acc_edge;
          rd  = resp_rdata[i];
          err = resp_err[i];
        end
      end
      if (lat < 0) timeout_fail("response");
      @(posedge clk);
      #2;
    end
  endtask

  logic [31:0] rd;
  bit          err;
  int          lat;
  bit          r, saw_wait;
  int          nacc, nresp, first;
  int          redge [3];

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #2;
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, req_ready[0]}, 32'd1);
    check("valid_after_reset", {31'd0, resp_valid[0]}, 32'd0);
    @(posedge clk);
    #2;

    // Write then read back with LATENCY=4.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, lat);
    check("wr10_latency", lat, 32'd4);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, err, lat);
    check("rd10_latency", lat, 32'd4);
    check("rd10_data", rd, 32'hDEADBEEF);

    // Address wrap: 0x1000 is word 1024 -> word 0.
    do_req(0, 1'b1, 32'h1000, 32'hA5, rd, err, lat);
    do_req(0, 1'b0, 32'h0, 32'h0, rd, err, lat);
    check("wrap_data", rd, 32'hA5);

    // Reset two cycles after accepting a write: write must vanish.
    do_req(0, 1'b1, 32'h8, 32'h11, rd, err, lat);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h8;
    req_wdata[0] = 32'h77;
    @(negedge clk);
    check("rst_pre_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #2;
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_resp", {31'd0, resp_valid[0]}, 32'd0);
    end
    @(posedge clk);
    #2;
    reset[0] = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #2;
    do_req(0, 1'b0, 32'h8, 32'h0, rd, err, lat);
    check("rst_prior_value", rd, 32'h11);

    // Misaligned write.
    do_req(0, 1'b1, 32'h10, 32'hCAFE0000, rd, err, lat);
    do_req(0, 1'b1, 32'h13, 32'h12345678, rd, err, lat);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_err", {31'd0, err}, 32'd1);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, err, lat);
    check("mis_mem_unchanged", rd, 32'hCAFE0000);
`else
    check("mis_err", {31'd0, err}, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, err, lat);
    check("mis_mem_written", rd, 32'h12345678);
`endif

    // Three back-to-back reads with req_valid held high.
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    nacc = 0;
    nresp = 0;
    first = -1;
    saw_wait = 1'b0;
    for (int t = 0; t < 60 && nresp < 3; t++) begin
      @(negedge clk);
      r = req_ready[0];
      if (!r) saw_wait = 1'b1;
      if (resp_valid[0]) begin
        redge[nresp] = cyc + 1;
        nresp++;
      end
      @(posedge clk);
      #1;
      if (r && req_valid[0]) begin
        if (nacc == 0) first = cyc;
        nacc++;
        if (nacc == 3) req_valid[0] = 1'b0;
        else req_addr[0] = (nacc == 1) ? 32'h8 : 32'h0;
      end
      #1;
    end
    if (nresp < 3) begin
      timeout_fail("b2b_responses");
    end else begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("b2b_edge%0d", j), redge[j] - first, 32'(4 * (j + 1)));
      end
    end
    check("b2b_ready_low_in_wait", {31'd0, saw_wait}, 32'd1);

    // LATENCY=1: write then read of same word accepted in RESP.
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h5;
    @(negedge clk);
    check("l1_ready", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #2;
    req_write[1] = 1'b0;
    req_wdata[1] = $urandom;
    @(negedge clk);
    check("l1_wr_resp", {31'd0, resp_valid[1]}, 32'd1);
    check("l1_ready_in_resp", {31'd0, req_ready[1]}, 32'd1);
    check("l1_wr_rdata_zero", resp_rdata[1], 32'd0);
    @(posedge clk);
    #2;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("l1_rd_resp", {31'd0, resp_valid[1]}, 32'd1);
    check("l1_rd_data", resp_rdata[1], 32'h5);
    @(posedge clk);
    #2;

    // Random traffic, including request fields that change while not accepted.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (reset[i] == 1'b0) reset[i] = 1'b1;
        else if ($urandom_range(0, 199) == 0) reset[i] = 1'b0;
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_write[i] = 1'($urandom);
        req_addr[i]  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2)
                     | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        req_wdata[i] = $urandom;
      end
      @(posedge clk);
      #2;
    end
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      reset[i] = 1'b1;
    end
    repeat (20) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
